mux2_burst_arbiter: RTL and testbench

- Shares one WIDTH-bit 2:1 mux datapath between two requesters using round-robin arbitration with bounded bursts.
- Generates the mux select and grants, and moves beats from the granted source into a registered output stage with valid/ready flow control.
- Sits between two producer blocks and a single downstream consumer. The consumer sees one merged stream.

---
 rtl/mux2_arb_pkg.sv | 21 ++
 rtl/mux_2x1_bus.sv | 13 +
 rtl/mux2_burst_arbiter.sv | 115 +++++++++++
 tb/tb_mux2_burst_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types and helpers for the two-requester burst arbiter.
// Arbiter state encoding, requester indices and burst-counter sizing.
package mux2_arb_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle = 2'd0,
    StG0   = 2'd1,
    StG1   = 2'd2
  } arb_state_e;

  localparam logic Req0 = 1'b0;
  localparam logic Req1 = 1'b1;

  // Wide enough to hold 0..max_burst.
  function automatic int unsigned cnt_width(int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux_2x1_bus.sv
// WIDTH-bit combinational 2:1 mux; sel=0 picks in0, sel=1 picks in1.
module mux_2x1_bus #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/mux2_burst_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one 2:1 mux datapath,
// feeding a single registered valid/ready output stage.
module mux2_burst_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic             vld0,
  input  logic             vld1,
  output logic             ack0,
  output logic             ack1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy
);

  localparam int unsigned CntW = cnt_width(MAX_BURST);

  arb_state_e      state;
  logic [CntW-1:0] cnt;
  logic            last;
  logic            space;
  logic            accept;
  logic            at_max;
  logic [WIDTH-1:0] mux_out;

  mux_2x1_bus #(
    .WIDTH (WIDTH)
  ) u_mux (
    .in0 (din0),
    .in1 (din1),
    .sel (sel),
    .y   (mux_out)
  );

  assign space  = ~dout_vld | dout_rdy;
  // A dropped req blocks acceptance in the same cycle even if vld is high.
  assign ack0   = (state == StG0) & req0 & vld0 & space;
  assign ack1   = (state == StG1) & req1 & vld1 & space;
  assign accept = ack0 | ack1;
  assign at_max = accept & (cnt == CntW'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      sel      <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      cnt      <= '0;
      last     <= Req1;
    end else begin
      if (accept) begin
        dout     <= mux_out;
        dout_vld <= 1'b1;
      end else if (dout_rdy) begin
        dout_vld <= 1'b0;
      end

      case (state)
        StIdle: begin
          if (req0 && (!req1 || last == Req1)) begin
            state <= StG0; gnt0 <= 1'b1; gnt1 <= 1'b0; sel <= 1'b0;
            last  <= Req0; cnt <= '0;
          end else if (req1) begin
            state <= StG1; gnt0 <= 1'b0; gnt1 <= 1'b1; sel <= 1'b1;
            last  <= Req1; cnt <= '0;
          end
        end
        StG0: begin
          if (!req0 || at_max) begin
            cnt <= '0;
            if (req1) begin
              state <= StG1; gnt0 <= 1'b0; gnt1 <= 1'b1; sel <= 1'b1;
              last  <= Req1;
            end else begin
              state <= StIdle; gnt0 <= 1'b0; gnt1 <= 1'b0; sel <= 1'b0;
            end
          end else if (accept) begin
            cnt <= cnt + 1'b1;
          end
        end
        StG1: begin
          if (!req1 || at_max) begin
            cnt <= '0;
            if (req0) begin
              state <= StG0; gnt0 <= 1'b1; gnt1 <= 1'b0; sel <= 1'b0;
              last  <= Req0;
            end else begin
              state <= StIdle; gnt0 <= 1'b0; gnt1 <= 1'b0; sel <= 1'b0;
            end
          end else if (accept) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= StIdle; gnt0 <= 1'b0; gnt1 <= 1'b0; sel <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_burst_arbiter.sv
// Self-checking bench for mux2_burst_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_mux2_burst_arbiter;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0, req1, vld0, vld1, dout_rdy;
  logic [WIDTH-1:0] din0, din1;
  logic             ack0, ack1, gnt0, gnt1, sel, dout_vld;
  logic [WIDTH-1:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux2_burst_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .din0     (din0),
    .din1     (din1),
    .vld0     (vld0),
    .vld1     (vld1),
    .ack0     (ack0),
    .ack1     (ack1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .sel      (sel),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  task automatic drive_idle();
    req0 = 1'b0; req1 = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
    din0 = '0; din1 = '0; dout_rdy = 1'b1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({gnt0, gnt1, sel, dout_vld, dout} !== 12'h000) begin
      errors++;
      $display("FAIL reset_in_reset got %b want 0", {gnt0, gnt1, sel, dout_vld, dout});
    end
    do_reset();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, sel, ack0, ack1, dout_vld} !== 6'b0) begin
      errors++;
      $display("FAIL reset_after got %b want 0", {gnt0, gnt1, sel, ack0, ack1, dout_vld});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_burst();
    bit exp_ack[9] = '{0, 1, 1, 1, 1, 0, 1, 0, 0};
    bit exp_g0[9]  = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
    logic [WIDTH-1:0] got[$];
    int idx = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (idx < 5) begin
        req0 = 1'b1; vld0 = 1'b1; din0 = 8'(8'h11 + idx);
      end else begin
        req0 = 1'b0; vld0 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({gnt0, ack0} !== {exp_g0[c], exp_ack[c]}) begin
        errors++;
        $display("FAIL burst_cycle%0d gnt0/ack0 got %b%b want %b%b", c, gnt0, ack0,
                 exp_g0[c], exp_ack[c]);
      end
      if (dout_vld) got.push_back(dout);
      if (ack0) idx++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL burst_beat_count got %0d want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== 8'(8'h11 + i)) begin
          errors++;
          $display("FAIL burst_data%0d got %h want %h", i, got[i], 8'(8'h11 + i));
        end
      end
    end
  endtask

  task automatic test_alternate();
    bit g0, g1;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; vld0 = 1'b1; vld1 = 1'b1;
    din0 = 8'h0A; din1 = 8'hB0; dout_rdy = 1'b1;
    for (int c = 0; c < 13; c++) begin
      g0 = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
      g1 = (c >= 5 && c <= 8);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, sel, ack0, ack1} !== {g0, g1, g1, g0, g1}) begin
        errors++;
        $display("FAIL alternate_cycle%0d got %b want %b", c,
                 {gnt0, gnt1, sel, ack0, ack1}, {g0, g1, g1, g0, g1});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_req_drop();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      req1 = 1'b1; vld1 = 1'b1; dout_rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
        din1 = 8'(8'hC0 + c);
        if (c >= 3) begin
          req1 = 1'b0;
          req0 = (v == 1);
        end
        @(negedge clk);
        if (c == 1 || c == 2) begin
          checks++;
          if (ack1 !== 1'b1) begin
            errors++;
            $display("FAIL drop_v%0d_beat%0d ack1 got %b want 1", v, c, ack1);
          end
        end
        if (c == 3) begin
          checks++;
          if ({gnt1, ack1} !== 2'b10) begin
            errors++;
            $display("FAIL drop_v%0d_noack gnt1/ack1 got %b want 10", v, {gnt1, ack1});
          end
        end
        if (c == 4) begin
          checks++;
          if ({gnt0, gnt1} !== {v == 1, 1'b0}) begin
            errors++;
            $display("FAIL drop_v%0d_next gnt0/gnt1 got %b want %b", v, {gnt0, gnt1},
                     {v == 1, 1'b0});
          end
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    do_reset();
    req0 = 1'b1; vld0 = 1'b1;
    for (int c = 0; c < 11; c++) begin
      din0 = 8'(8'h20 + idx);
      dout_rdy = !(c >= 3 && c <= 7);
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        checks++;
        if ({ack0, dout_vld, dout, gnt0} !== {1'b0, 1'b1, 8'h21, 1'b1}) begin
          errors++;
          $display("FAIL stall_cycle%0d ack0/vld/dout/gnt0 got %b %b %h %b want 0 1 21 1", c,
                   ack0, dout_vld, dout, gnt0);
        end
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (ack0 !== 1'b1) begin
          errors++;
          $display("FAIL stall_resume%0d ack0 got %b want 1", c, ack0);
        end
      end
      if (c == 10) begin
        checks++;
        if (gnt0 !== 1'b0 || idx != 4) begin
          errors++;
          $display("FAIL stall_release gnt0 got %b beats %0d want 0 and 4", gnt0, idx);
        end
      end
      if (ack0) idx++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req0 = 1'b1; vld0 = 1'b1; din0 = 8'h55; dout_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, sel, dout_vld} !== 4'b0) begin
      errors++;
      $display("FAIL async_reset got %b want 0000", {gnt0, gnt1, sel, dout_vld});
    end
    req0 = 1'b0; vld0 = 1'b0; req1 = 1'b1; vld1 = 1'b1; din1 = 8'h66;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, sel} !== 3'b011) begin
      errors++;
      $display("FAIL async_regrant got %b want 011", {gnt0, gnt1, sel});
    end
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b1) begin
      errors++;
      $display("FAIL async_ack1 got %b want 1", ack1);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({dout_vld, dout} !== {1'b1, 8'h66}) begin
      errors++;
      $display("FAIL async_dout got %b %h want 1 66", dout_vld, dout);
    end
  endtask

  task automatic test_tie();
    do_reset();
    req1 = 1'b1; vld1 = 1'b1; din1 = 8'hA5; dout_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin req1 = 1'b0; vld1 = 1'b0; end
      if (c == 3) begin req0 = 1'b1; req1 = 1'b1; end
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({gnt0, gnt1, sel, ack1} !== 4'b0111) begin
          errors++;
          $display("FAIL tie_g1 gnt0/gnt1/sel/ack1 got %b want 0111", {gnt0, gnt1, sel, ack1});
        end
      end
      if (c == 2) begin
        checks++;
        if ({dout_vld, dout} !== {1'b1, 8'hA5}) begin
          errors++;
          $display("FAIL tie_dout got %b %h want 1 a5", dout_vld, dout);
        end
      end
      if (c == 4) begin
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
          errors++;
          $display("FAIL tie_to_0 gnt0/gnt1 got %b want 10", {gnt0, gnt1});
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    int owner = -1;
    int mcnt = 0;
    int mlast = 1;
    bit mvld = 1'b0;
    logic [WIDTH-1:0] mdout = '0;
    bit e_g0, e_g1, e_a0, e_a1, spc, mine, other;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req0 = ($urandom_range(0, 9) < 7);
      req1 = ($urandom_range(0, 9) < 7);
      vld0 = ($urandom_range(0, 3) != 0);
      vld1 = ($urandom_range(0, 3) != 0);
      din0 = 8'($urandom);
      din1 = 8'($urandom);
      dout_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e_g0 = (owner == 0);
      e_g1 = (owner == 1);
      spc  = !mvld || dout_rdy;
      e_a0 = e_g0 && req0 && vld0 && spc;
      e_a1 = e_g1 && req1 && vld1 && spc;
      checks++;
      if ({gnt0, gnt1, sel, ack0, ack1, dout_vld} !== {e_g0, e_g1, e_g1, e_a0, e_a1, mvld}) begin
        errors++;
        $display("FAIL rand_ctrl%0d got %b want %b", c, {gnt0, gnt1, sel, ack0, ack1, dout_vld},
                 {e_g0, e_g1, e_g1, e_a0, e_a1, mvld});
      end
      if (mvld) begin
        checks++;
        if (dout !== mdout) begin
          errors++;
          $display("FAIL rand_dout%0d got %h want %h", c, dout, mdout);
        end
      end
      if (e_a0 || e_a1) begin
        mdout = e_a0 ? din0 : din1;
        mvld  = 1'b1;
      end else if (dout_rdy) begin
        mvld = 1'b0;
      end
      if (owner < 0) begin
        if (req0 && req1) owner = 1 - mlast;
        else if (req0) owner = 0;
        else if (req1) owner = 1;
        if (owner >= 0) begin
          mlast = owner;
          mcnt  = 0;
        end
      end else begin
        mine  = (owner == 0) ? req0 : req1;
        other = (owner == 0) ? req1 : req0;
        if (e_a0 || e_a1) mcnt++;
        if (!mine || mcnt == MAX_BURST) begin
          mcnt = 0;
          if (other) begin
            owner = 1 - owner;
            mlast = owner;
          end else begin
            owner = -1;
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_alternate();
    test_req_drop();
    test_backpressure();
    test_async_reset();
    test_tie();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
